// File: rtl/meteor_field_engine_if.sv
// Text-buffer write port shared with the VGA RAM arbiter.
// The engine holds vga_addr/vga_data stable while vga_we is high and vga_ready is low.
interface meteor_field_engine_if #(
  parameter int ADDR_W = 12
);
  logic              vga_we;
  logic [ADDR_W-1:0] vga_addr;
  logic [15:0]       vga_data;
  logic              vga_ready;

  modport master (output vga_we, vga_addr, vga_data, input vga_ready);
  modport slave  (input vga_we, vga_addr, vga_data, output vga_ready);
endinterface

// File: rtl/meteor_field_engine.sv
// Draws a playfield border into the text buffer, then animates falling meteors
// on a periodic tick and reports hits against the player column.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// BORDER    | writing border cells, one handshake per cell
// WAIT_TICK | animation idle until a tick is pending
// ERASE     | blanking the current meteor at its old position
// MOVE      | one cycle: advance or wrap the current meteor, hit test
// DRAW      | writing the meteor glyph at its new position
module meteor_field_engine #(
  parameter int NUM_METEORS  = 4,
  parameter int COLS         = 80,
  parameter int ADDR_W       = 12,
  parameter int FIELD_TOP    = 1,
  parameter int FIELD_BOTTOM = 19,
  parameter int FIELD_LEFT   = 1,
  parameter int FIELD_RIGHT  = 29,
  parameter int INIT_SPACING = 5,
  parameter int TICK_CYCLES  = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  enable,
  input  logic [6:0]            player_col,
  meteor_field_engine_if.master vga,
  output logic                  busy,
  output logic                  hit,
  output logic [7:0]            hit_count,
  output logic                  overrun
);

  localparam int W      = FIELD_RIGHT - FIELD_LEFT + 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [6:0] TOP    = 7'(FIELD_TOP);
  localparam logic [6:0] BOT    = 7'(FIELD_BOTTOM);
  localparam logic [6:0] LEFT   = 7'(FIELD_LEFT);
  localparam logic [6:0] WALL_L = 7'(FIELD_LEFT - 1);
  localparam logic [6:0] WALL_R = 7'(FIELD_RIGHT + 1);
  localparam logic [6:0] ROW_T  = 7'(FIELD_TOP - 1);
  localparam logic [6:0] ROW_B  = 7'(FIELD_BOTTOM + 1);
  localparam logic [6:0] W7     = 7'(W);
  localparam logic [2:0] LAST   = 3'(NUM_METEORS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, BORDER, WAIT_TICK, ERASE, MOVE, DRAW} state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic              pending;
  logic [6:0]        b_row, b_col;
  logic [6:0]        m_row [8];
  logic [6:0]        m_col [8];
  logic [2:0]        m_idx;

  logic [6:0] nb_row, nb_col;
  logic       nb_done;
  logic [6:0] cur_row, cur_col, step, off, new_row, new_col;
  logic       wrap;
  logic [2:0] nxt_idx;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [6:0] r, input logic [6:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  function automatic logic [15:0] border_data(input logic [6:0] r);
    if (r == ROW_T) return 16'h0F09;
    if (r == ROW_B) return 16'h0F08;
    return 16'h0F0F;
  endfunction

  // Next border cell: full top/bottom rows, left+right walls in between.
  always_comb begin
    nb_row  = b_row;
    nb_col  = b_col;
    nb_done = 1'b0;
    if (b_row == ROW_T || b_row == ROW_B) begin
      if (b_col != WALL_R) begin
        nb_col = b_col + 7'd1;
      end else if (b_row == ROW_B) begin
        nb_done = 1'b1;
      end else begin
        nb_row = b_row + 7'd1;
        nb_col = WALL_L;
      end
    end else if (b_col == WALL_L) begin
      nb_col = WALL_R;
    end else begin
      nb_row = b_row + 7'd1;
      nb_col = WALL_L;
    end
  end

  // Current meteor's next position; the column step wraps with one conditional subtract.
  always_comb begin
    cur_row = m_row[m_idx];
    cur_col = m_col[m_idx];
    step    = {3'b000, m_idx, 1'b0} + 7'd3;
    off     = cur_col - LEFT + step;
    if (off >= W7) off = off - W7;
    wrap    = (cur_row >= BOT);
    new_row = wrap ? TOP : cur_row + 7'd1;
    new_col = wrap ? LEFT + off : cur_col;
    nxt_idx = m_idx + 3'd1;
  end

  // Sequencer, write port, meteor state and tick counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      vga.vga_we   <= 1'b0;
      vga.vga_addr <= '0;
      vga.vga_data <= '0;
      busy         <= 1'b0;
      hit          <= 1'b0;
      hit_count    <= '0;
      overrun      <= 1'b0;
      tick_cnt     <= '0;
      pending      <= 1'b0;
      b_row        <= '0;
      b_col        <= '0;
      m_idx        <= '0;
      for (int i = 0; i < 8; i++) begin
        m_row[i] <= TOP;
        m_col[i] <= 7'(FIELD_LEFT + ((i * INIT_SPACING) % W));
      end
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= BORDER;
            busy         <= 1'b1;
            b_row        <= ROW_T;
            b_col        <= WALL_L;
            vga.vga_we   <= 1'b1;
            vga.vga_addr <= addr_of(ROW_T, WALL_L);
            vga.vga_data <= 16'h0F09;
          end
        end
        BORDER: begin
          if (vga.vga_we && vga.vga_ready) begin
            if (nb_done) begin
              vga.vga_we <= 1'b0;
              busy       <= 1'b0;
              state      <= WAIT_TICK;
            end else begin
              b_row        <= nb_row;
              b_col        <= nb_col;
              vga.vga_addr <= addr_of(nb_row, nb_col);
              vga.vga_data <= border_data(nb_row);
            end
          end
        end
        WAIT_TICK: begin
          if (pending) begin
            pending      <= 1'b0;
            m_idx        <= '0;
            busy         <= 1'b1;
            state        <= ERASE;
            vga.vga_we   <= 1'b1;
            vga.vga_addr <= addr_of(m_row[0], m_col[0]);
            vga.vga_data <= 16'h0020;
          end
        end
        ERASE: begin
          if (vga.vga_we && vga.vga_ready) begin
            vga.vga_we <= 1'b0;
            state      <= MOVE;
          end
        end
        MOVE: begin
          m_row[m_idx] <= new_row;
          m_col[m_idx] <= new_col;
          if (wrap && cur_col == player_col) begin
            hit <= 1'b1;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          end
          state        <= DRAW;
          vga.vga_we   <= 1'b1;
          vga.vga_addr <= addr_of(new_row, new_col);
          vga.vga_data <= 16'h0E09;
        end
        DRAW: begin
          if (vga.vga_we && vga.vga_ready) begin
            if (m_idx == LAST) begin
              vga.vga_we <= 1'b0;
              busy       <= 1'b0;
              state      <= WAIT_TICK;
            end else begin
              m_idx        <= nxt_idx;
              state        <= ERASE;
              vga.vga_addr <= addr_of(m_row[nxt_idx], m_col[nxt_idx]);
              vga.vga_data <= 16'h0020;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the FSM so a tick landing on the consume cycle is not lost.
      if (state != IDLE && enable) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          pending  <= 1'b1;
          if (pending) overrun <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/meteor_field_engine.md
Name: meteor_field_engine

Overview:
Parametrised successor to the fixed four-meteor text-mode sample FSM. On `start` it draws a rectangular playfield border into the 80-column VGA text buffer. It then animates NUM_METEORS falling glyphs on a periodic tick and reports hits against a player column. All buffer writes use a valid/ready write port, so the block can share the text RAM through an arbiter.

Parameters:
NUM_METEORS, 4, number of meteors (1..8)
COLS, 80, text-buffer row pitch in characters
ADDR_W, 12, VGA address width
FIELD_TOP, 1, first playable row
FIELD_BOTTOM, 19, last playable row
FIELD_LEFT, 1, first playable column
FIELD_RIGHT, 29, last playable column
INIT_SPACING, 5, column spacing of initial meteor positions
TICK_CYCLES, 1000000, clk cycles per animation tick

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; draw border, then begin animation
enable  in  1  1 = tick counter runs; 0 = paused
player_col  in  7  player column for hit test
vga_ready  in  1  write accepted when vga_we && vga_ready
vga_we  out  1  write request
vga_addr  out  ADDR_W  write address = row*COLS + col
vga_data  out  16  {attr, char} word
busy  out  1  high in BORDER/ERASE/MOVE/DRAW
hit  out  1  one-cycle pulse on meteor/player hit
hit_count  out  8  saturating hit counter
overrun  out  1  sticky; tick arrived while a tick was already pending

Behaviour:
- Derived values: W = FIELD_RIGHT-FIELD_LEFT+1. Meteor i uses STEP_i = 2*i+3.
- Reset (rst=0, asynchronous):
  - state IDLE; vga_we=0, vga_addr=0, vga_data=0; busy=0, hit=0, hit_count=0, overrun=0.
  - Tick counter 0, pending 0.
  - Meteor i: row=FIELD_TOP, col=FIELD_LEFT+((i*INIT_SPACING) mod W).
  - Reset mid-operation abandons any write and any partial frame.
- Write handshake:
  - vga_we is registered.
  - While vga_we=1 and vga_ready=0, vga_addr and vga_data hold stable.
  - A write completes on the clk edge where both are 1. vga_we drops the next cycle unless the next write is issued back-to-back.
- States: IDLE, BORDER, WAIT_TICK, ERASE, MOVE, DRAW.
- IDLE -> BORDER on start. start is ignored in all other states.
- BORDER write order, each cell one handshake:
  - Row FIELD_TOP-1, cols FIELD_LEFT-1..FIELD_RIGHT+1, data 0x0F09.
  - Then for each row FIELD_TOP..FIELD_BOTTOM: left wall (FIELD_LEFT-1), then right wall (FIELD_RIGHT+1), data 0x0F0F.
  - Then row FIELD_BOTTOM+1, cols FIELD_LEFT-1..FIELD_RIGHT+1, data 0x0F08.
  - After the last accepted write -> WAIT_TICK.
- Tick counter:
  - Increments when enable=1 in any non-IDLE state.
  - At TICK_CYCLES-1 it wraps to 0 and sets pending.
  - If pending is already 1 at that moment, overrun is set; it stays set until reset.
- WAIT_TICK: if pending, clear it and start a frame at meteor 0. Meteors are processed in index order.
- ERASE: write 0x0020 at the meteor's current address.
- MOVE (1 cycle, no write):
  - If row < FIELD_BOTTOM: row += 1.
  - Else:
    - If col == player_col: hit=1 for this cycle and hit_count increments, saturating at 255.
    - row = FIELD_TOP.
    - col = FIELD_LEFT + ((col - FIELD_LEFT + STEP_i) mod W).
- DRAW: write 0x0E09 at the new address.
- After DRAW, go to the next meteor's ERASE, or to WAIT_TICK after meteor NUM_METEORS-1.
- Meteors are never drawn at their reset positions. The first visible draw of each meteor is at FIELD_TOP+1.
- enable=0 freezes only the tick counter. An in-progress frame or border always completes.
- Arithmetic:
  - Address computed at ADDR_W bits.
  - Row/col are 7-bit unsigned.
  - The mod W step is computed with a single conditional subtract; STEP_i < W is required.

Test Plan:
- Defaults, start, vga_ready=1 -> exactly 100 writes. First is addr 0 / 0x0F09; second is addr 1 / 0x0F09. Addr 80 / 0x0F0F precedes addr 110 / 0x0F0F. Last is addr 1630 / 0x0F08. busy falls after write 100.
- After border, TICK_CYCLES=8 -> after 8 cycles, first frame writes in order: 81/0x0020, 161/0x0E09, 86/0x0020, 166/0x0E09, then meteor 2 (col 11), then meteor 3 (col 16).
- player_col=1, run 19 ticks -> meteor 0 wraps on tick 19. hit pulses once, hit_count=1, and its DRAW is addr 84 / 0x0E09.
- vga_ready=0 for 5 cycles during an ERASE -> vga_we, addr and data stay constant. Exactly one write is accepted when vga_ready returns to 1.
- TICK_CYCLES=4 with vga_ready held 0 for 12 cycles mid-frame -> overrun=1 and stays 1 after the frame completes.
- Assert rst=0 in the middle of BORDER -> all outputs return to 0 in the same cycle. The next start redraws the border from addr 0.
